// File: rtl/i2s_mic_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2s_mic_rx                                                    |
// | Purpose  : I2S receive master for the microphone path; drives ws and     |
// |            deserialises sd into stereo left/right sample pairs.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module i2s_mic_rx #(
  parameter int SLOT_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              sd,
  output logic              ws,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              valid
);

  localparam int                 c_cnt_w     = $clog2(2 * SLOT_W);
  localparam logic [c_cnt_w-1:0] c_last      = c_cnt_w'(2 * SLOT_W - 1);
  localparam logic [c_cnt_w-1:0] c_slot      = c_cnt_w'(SLOT_W);
  localparam logic [c_cnt_w-1:0] c_data      = c_cnt_w'(DATA_W);
  localparam logic [c_cnt_w-1:0] c_data_last = c_cnt_w'(DATA_W - 1);

  logic               r_sck_q;
  logic [c_cnt_w-1:0] r_bit_cnt;
  logic [DATA_W-1:0]  r_shreg;
  logic [DATA_W-1:0]  r_left_hold;
  logic               r_left_ok;

  logic               w_rise;
  logic               w_fall;
  logic [c_cnt_w-1:0] w_cnt_next;
  logic [c_cnt_w-1:0] w_p;
  logic               w_right;
  logic [c_cnt_w-1:0] w_slot;
  logic [DATA_W:0]    w_shift_full;
  logic [DATA_W-1:0]  w_word;

  // The bit sampled on a rise belongs to the previous counter position (I2S one-bit delay).
  always_comb begin
    w_rise       = sck & ~r_sck_q;
    w_fall       = ~sck & r_sck_q;
    w_cnt_next   = (r_bit_cnt == c_last) ? '0 : r_bit_cnt + c_cnt_w'(1);
    w_p          = (r_bit_cnt == '0) ? c_last : r_bit_cnt - c_cnt_w'(1);
    w_right      = (w_p >= c_slot);
    w_slot       = w_right ? (w_p - c_slot) : w_p;
    w_shift_full = {r_shreg, sd};
    w_word       = w_shift_full[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck_q     <= 1'b0;
      r_bit_cnt   <= '0;
      ws          <= 1'b0;
      r_shreg     <= '0;
      r_left_hold <= '0;
      r_left_ok   <= 1'b0;
      left_data   <= '0;
      right_data  <= '0;
      valid       <= 1'b0;
    end else begin
      r_sck_q <= sck;
      valid   <= 1'b0;
      if (w_fall) begin
        r_bit_cnt <= w_cnt_next;
        ws        <= (w_cnt_next >= c_slot);
      end
      if (w_rise) begin
        if (w_slot < c_data) begin
          r_shreg <= w_word;
        end
        // A right word only publishes when a matching left word precedes it.
        if (w_slot == c_data_last) begin
          if (!w_right) begin
            r_left_hold <= w_word;
            r_left_ok   <= 1'b1;
          end else if (r_left_ok) begin
            left_data  <= r_left_hold;
            right_data <= w_word;
            valid      <= 1'b1;
            r_left_ok  <= 1'b0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_mic_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_i2s_mic_rx                                                 |
// | Purpose  : Directed self-checking bench for i2s_mic_rx (16- and 12-bit). |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_i2s_mic_rx;

  localparam logic [15:0] c_l16 = 16'hA5C3;
  localparam logic [15:0] c_r16 = 16'h1234;
  localparam logic [15:0] c_l12 = 16'hABC7;
  localparam logic [15:0] c_r12 = 16'h3216;

  logic        clk;
  logic        reset;
  logic        sck;
  logic        sd16;
  logic        sd12;
  logic        hold;
  logic        ws16;
  logic        valid16;
  logic [15:0] left16;
  logic [15:0] right16;
  logic        ws12;
  logic        valid12;
  logic [11:0] left12;
  logic [11:0] right12;

  int errors;
  int checks;
  int mic_cnt;
  int fall_total;
  int period_idx;

  i2s_mic_rx #(.SLOT_W(16), .DATA_W(16)) dut16 (
    .clk(clk), .reset(reset), .sck(sck), .sd(sd16),
    .ws(ws16), .left_data(left16), .right_data(right16), .valid(valid16)
  );

  i2s_mic_rx #(.SLOT_W(16), .DATA_W(12)) dut12 (
    .clk(clk), .reset(reset), .sck(sck), .sd(sd12),
    .ws(ws12), .left_data(left12), .right_data(right12), .valid(valid12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic half_phase(input int n);
    int i;
    i = 0;
    while (i < n) begin
      @(negedge clk);
      if (reset) begin
        mic_cnt    = 0;
        fall_total = 0;
      end
      if (!hold) i++;
    end
  endtask

  // Mic model: MSB appears one SCK after the slot boundary.
  task automatic drive_sd();
    int p;
    int s;
    logic [15:0] w16;
    logic [15:0] w12;
    p    = (mic_cnt + 31) % 32;
    s    = p % 16;
    w16  = (p < 16) ? c_l16 : c_r16;
    w12  = (p < 16) ? c_l12 : c_r12;
    sd16 = w16[15-s];
    sd12 = w12[15-s];
  endtask

  // SCK: periods of 31,31,31,32 clk -> exactly 1000 clk per 32-SCK frame.
  initial begin : sck_gen
    sck = 1'b0; sd16 = 1'b0; sd12 = 1'b0;
    mic_cnt = 0; fall_total = 0; period_idx = 0;
    forever begin
      sck = 1'b1;
      half_phase(16);
      sck = 1'b0;
      if (!reset) begin
        mic_cnt = (mic_cnt + 1) % 32;
        fall_total++;
      end
      drive_sd();
      half_phase((period_idx % 4 == 3) ? 16 : 15);
      period_idx++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_sck_rise();
    logic prev;
    bit   ok;
    ok   = 1'b0;
    prev = sck;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (sck && !prev) ok = 1'b1;
      prev = sck;
    end
    chk("sck_rise_seen", 64'(ok), 64'd1);
  endtask

  task automatic wait_valid(input int sel, input int max, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (n < max && !ok) begin
      tick();
      n++;
      if ((sel == 0) ? valid16 : valid12) ok = 1'b1;
    end
  endtask

  initial begin : stim
    int  n;
    bit  ok;
    int  viol;
    int  toggles;
    int  falls_since;
    bit  first_toggle;
    logic prev_ws;
    logic prev_sck;
    logic ws0;
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    hold   = 1'b0;

    // Reset held while sck toggles
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i % 10 == 0) begin
        chk("reset_outs16", {30'd0, ws16, valid16, left16, right16}, 64'd0);
        chk("reset_valid12", {63'd0, valid12}, 64'd0);
      end
    end
    wait_sck_rise();
    repeat (3) tick();
    reset = 1'b0;

    // First pair follows the first full frame
    wait_valid(0, 3000, n, ok);
    chk("first_valid_seen", 64'(ok), 64'd1);
    chk("first_valid_falls", 64'(fall_total), 64'd32);
    chk("first_left", 64'(left16), 64'(c_l16));
    chk("first_right", 64'(right16), 64'(c_r16));
    for (int f = 0; f < 3; f++) begin
      tick();
      chk("valid_one_clk", 64'(valid16), 64'd0);
      wait_valid(0, 1100, n, ok);
      chk("frame_valid_seen", 64'(ok), 64'd1);
      chk("frame_clks", 64'(n), 64'd999);
      chk("frame_left", 64'(left16), 64'(c_l16));
      chk("frame_right", 64'(right16), 64'(c_r16));
    end

    // 12-bit capture ignores the trailing four slot bits
    for (int f = 0; f < 2; f++) begin
      wait_valid(1, 1100, n, ok);
      chk("d12_valid_seen", 64'(ok), 64'd1);
      chk("d12_left", 64'(left12), 64'h0ABC);
      chk("d12_right", 64'(right12), 64'h0321);
    end

    // ws toggles every 16 falls and only while sck is low
    toggles = 0; falls_since = 0; first_toggle = 1'b1;
    prev_ws = ws16; prev_sck = sck;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (prev_sck && !sck) falls_since++;
      if (ws16 !== prev_ws) begin
        toggles++;
        chk("ws_on_fall_sck", 64'(sck), 64'd0);
        chk("ws_vs_model", 64'(ws16), 64'(mic_cnt >= 16));
        if (!first_toggle) chk("ws_period_falls", 64'(falls_since), 64'd16);
        first_toggle = 1'b0;
        falls_since  = 0;
      end
      prev_ws  = ws16;
      prev_sck = sck;
    end
    chk("ws_toggles_2frames", 64'(toggles), 64'd4);

    // sck frozen high mid-frame
    wait_sck_rise();
    repeat (3) tick();
    ws0 = ws16;
    hold = 1'b1;
    viol = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (valid16 || ws16 !== ws0 || left16 !== c_l16 || right16 !== c_r16 || sck !== 1'b1)
        viol++;
    end
    hold = 1'b0;
    chk("hold_no_change", 64'(viol), 64'd0);
    wait_valid(0, 2000, n, ok);
    chk("hold_resume_valid", 64'(ok), 64'd1);
    chk("hold_resume_left", 64'(left16), 64'(c_l16));
    chk("hold_resume_right", 64'(right16), 64'(c_r16));

    // Reset pulse in the middle of the right slot
    n = 0;
    while (n < 2000 && !(mic_cnt == 24 && sck == 1'b0)) begin
      tick();
      n++;
    end
    chk("reach_right_slot", 64'(mic_cnt), 64'd24);
    wait_sck_rise();
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("midrst_async_clear", {30'd0, ws16, valid16, left16, right16}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_held", {30'd0, ws16, valid16, left16, right16}, 64'd0);
    end
    reset = 1'b0;
    wait_valid(0, 3000, n, ok);
    chk("midrst_valid_seen", 64'(ok), 64'd1);
    chk("midrst_full_frame", 64'(fall_total), 64'd32);
    chk("midrst_left", 64'(left16), 64'(c_l16));
    chk("midrst_right", 64'(right16), 64'(c_r16));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
